mmc1_write_sequencer: RTL and testbench

- Host-side controller that configures the MMC1 mapper through its native serial interface.
- Takes one parallel register write (register select + 5-bit value) or a shift-register reset request per handshake. Emits the CPU-bus cycles the MMC1 samples: five LSB-first serial writes, or one D7 reset write.
- Sits between a loader/test host and the MMC1 CPU-side pins; also keeps a shadow of the mapper register file.

---
 rtl/mmc1_write_sequencer_if.sv | 30 +++
 rtl/mmc1_write_sequencer.sv | 131 +++++++++++++
 tb/tb_mmc1_write_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mmc1_write_sequencer_if.sv
// mmc1_write_sequencer_if: host request handshake, MMC1 CPU-side bus and shadow register file
interface mmc1_write_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_reg;
    logic [4:0] req_data;
    logic       req_reset;
    logic       done;
    logic       CPU_M2;
    logic       nCPU_ROMSEL;
    logic       nCPU_RW;
    logic       CPU_A14;
    logic       CPU_A13;
    logic       CPU_D0;
    logic       CPU_D7;
    logic [4:0] shadow_control;
    logic [4:0] shadow_chr0;
    logic [4:0] shadow_chr1;
    logic [4:0] shadow_prg;
    modport master (
        output req_valid, req_reg, req_data, req_reset,
        input  req_ready, done, CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7,
        input  shadow_control, shadow_chr0, shadow_chr1, shadow_prg
    );
    modport slave (
        input  req_valid, req_reg, req_data, req_reset,
        output req_ready, done, CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7,
        output shadow_control, shadow_chr0, shadow_chr1, shadow_prg
    );
endinterface

// File: rtl/mmc1_write_sequencer.sv
// mmc1_write_sequencer: turns register writes / shift resets into MMC1 serial CPU-bus cycles.
// Define MMC1_SEQ_AUTO_RESYNC_EN to prefix every write with a shift-register reset cycle.
module mmc1_write_sequencer #(
    parameter int unsigned SETUP_CLKS = 2,
    parameter int unsigned HOLD_CLKS  = 2,
    parameter int unsigned GAP_CLKS   = 2
) (
    input logic                  CLK,
    input logic                  nRST,
    mmc1_write_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, ACTIVE, RECOVER} state_t;
    localparam logic [7:0] SETUP_M1 = 8'(SETUP_CLKS - 1);
    localparam logic [7:0] HOLD_M1  = 8'(HOLD_CLKS - 1);
    localparam logic [7:0] GAP_M1   = 8'(GAP_CLKS - 1);
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] reg_q, reg_d;
    logic [4:0] data_q, data_d;
    logic       rst_q, rst_d;
    logic       cyc_rst_q, cyc_rst_d;
    logic       last, done_d, busy;
    // cyc_rst marks the current bus cycle as a D7 reset cycle; rst marks a pure reset request
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        reg_d     = reg_q;
        data_d    = data_q;
        rst_d     = rst_q;
        cyc_rst_d = cyc_rst_q;
        done_d    = 1'b0;
        last      = cyc_rst_q ? rst_q : (bit_q == 3'd4);
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d   = SETUP;
                cnt_d     = SETUP_M1;
                bit_d     = 3'd0;
                reg_d     = bus.req_reg;
                data_d    = bus.req_data;
                rst_d     = bus.req_reset;
`ifdef MMC1_SEQ_AUTO_RESYNC_EN
                cyc_rst_d = 1'b1;
`else
                cyc_rst_d = bus.req_reset;
`endif
            end
            SETUP: begin
                state_d = (cnt_q == 8'd0) ? STROBE : SETUP;
                cnt_d   = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
            end
            STROBE: begin
                state_d = ACTIVE;
                cnt_d   = HOLD_M1;
            end
            ACTIVE: begin
                state_d = (cnt_q == 8'd0) ? RECOVER : ACTIVE;
                cnt_d   = (cnt_q == 8'd0) ? GAP_M1 : cnt_q - 8'd1;
            end
            RECOVER: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            else if (last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d   = SETUP;
                cnt_d     = SETUP_M1;
                bit_d     = cyc_rst_q ? 3'd0 : bit_q + 3'd1;
                cyc_rst_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        busy = state_d != IDLE;
    end
    // bus pins are registered from the next state so they line up with state_q
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q            <= IDLE;
            cnt_q              <= 8'd0;
            bit_q              <= 3'd0;
            reg_q              <= 2'd0;
            data_q             <= 5'd0;
            rst_q              <= 1'b0;
            cyc_rst_q          <= 1'b0;
            bus.req_ready      <= 1'b1;
            bus.done           <= 1'b0;
            bus.CPU_M2         <= 1'b0;
            bus.nCPU_ROMSEL    <= 1'b1;
            bus.nCPU_RW        <= 1'b1;
            bus.CPU_A14        <= 1'b0;
            bus.CPU_A13        <= 1'b0;
            bus.CPU_D0         <= 1'b0;
            bus.CPU_D7         <= 1'b0;
            bus.shadow_control <= 5'b01100;
            bus.shadow_chr0    <= 5'd0;
            bus.shadow_chr1    <= 5'd0;
            bus.shadow_prg     <= 5'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_q           <= bit_d;
            reg_q           <= reg_d;
            data_q          <= data_d;
            rst_q           <= rst_d;
            cyc_rst_q       <= cyc_rst_d;
            bus.req_ready   <= !busy;
            bus.done        <= done_d;
            bus.CPU_M2      <= state_d == STROBE || state_d == ACTIVE;
            bus.nCPU_ROMSEL <= state_d != ACTIVE;
            bus.nCPU_RW     <= state_d == IDLE || state_d == RECOVER;
            bus.CPU_A14     <= busy & reg_d[1];
            bus.CPU_A13     <= busy & reg_d[0];
            bus.CPU_D0      <= busy & ~cyc_rst_d & data_d[bit_d];
            bus.CPU_D7      <= busy & cyc_rst_d;
            if (done_d) begin
                if (rst_q) bus.shadow_control[3:2] <= 2'b11;
                else begin
`ifdef MMC1_SEQ_AUTO_RESYNC_EN
                    bus.shadow_control[3:2] <= 2'b11;
`endif
                    unique case (reg_q)
                        2'd0: bus.shadow_control <= data_q;
                        2'd1: bus.shadow_chr0    <= data_q;
                        2'd2: bus.shadow_chr1    <= data_q;
                        default: bus.shadow_prg  <= data_q;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_mmc1_write_sequencer.sv
// tb_mmc1_write_sequencer: directed and random requests on a default (P=7) and a minimal (P=4) sequencer,
// checked against a bus-capture / shadow-register model.
module tb_mmc1_write_sequencer;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic sel = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] sh [2][4];

    always #5 CLK = ~CLK;

    mmc1_write_sequencer_if ia ();
    mmc1_write_sequencer_if ib ();

    mmc1_write_sequencer dut_a (.CLK(CLK), .nRST(nRST), .bus(ia.slave));
    mmc1_write_sequencer #(.SETUP_CLKS(1), .HOLD_CLKS(1), .GAP_CLKS(1)) dut_b (.CLK(CLK), .nRST(nRST), .bus(ib.slave));

    wire m2     = sel ? ib.CPU_M2      : ia.CPU_M2;
    wire romsel = sel ? ib.nCPU_ROMSEL : ia.nCPU_ROMSEL;
    wire rw     = sel ? ib.nCPU_RW     : ia.nCPU_RW;
    wire a14    = sel ? ib.CPU_A14     : ia.CPU_A14;
    wire a13    = sel ? ib.CPU_A13     : ia.CPU_A13;
    wire d0     = sel ? ib.CPU_D0      : ia.CPU_D0;
    wire d7     = sel ? ib.CPU_D7      : ia.CPU_D7;
    wire ready  = sel ? ib.req_ready   : ia.req_ready;
    wire done   = sel ? ib.done        : ia.done;
    wire [19:0] shv = sel ? {ib.shadow_prg, ib.shadow_chr1, ib.shadow_chr0, ib.shadow_control}
                          : {ia.shadow_prg, ia.shadow_chr1, ia.shadow_chr0, ia.shadow_control};

    function automatic int per();
        return sel ? 4 : 7;
    endfunction

    function automatic int hold();
        return sel ? 1 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (dut %0d): got %0h expected %0h", tag, sel, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] r, input logic [4:0] d, input logic rs);
        ia.req_valid = v & ~sel; ia.req_reg = r; ia.req_data = d; ia.req_reset = rs;
        ib.req_valid = v & sel;  ib.req_reg = r; ib.req_data = d; ib.req_reset = rs;
    endtask

    task automatic reset_model();
        for (int s = 0; s < 2; s++) begin
            sh[s][0] = 5'b01100;
            for (int i = 1; i < 4; i++) sh[s][i] = 5'd0;
        end
    endtask

    task automatic check_shadows(input string tag);
        for (int i = 0; i < 4; i++) check(tag, 32'(shv[5*i +: 5]), 32'(sh[sel][i]));
    endtask

    // Called at a negedge with the sequencer idle; returns at the negedge of the done clock.
    task automatic run_req(input logic [1:0] r, input logic [4:0] d, input logic rs, input logic keep);
        logic [1:0] exp_cap[$];
        logic [1:0] cap[$];
        int n = 0, low = 0, lat;
        logic prev = 1'b1, seen = 1'b0;
        if (rs) exp_cap.push_back(2'b10);
        else begin
`ifdef MMC1_SEQ_AUTO_RESYNC_EN
            exp_cap.push_back(2'b10);
`endif
            for (int i = 0; i < 5; i++) exp_cap.push_back({1'b0, d[i]});
        end
        lat = exp_cap.size() * per() + 1;
        drive(1'b1, r, d, rs);
        check("ready_at_request", 32'(ready), 32'd1);
        @(posedge CLK);
        #1 drive(keep, 2'($urandom), 5'($urandom), 1'($urandom));
        while (!seen && n < lat + 20) begin
            @(negedge CLK);
            n++;
            if (!romsel) low++;
            if (prev && !romsel) begin
                cap.push_back({d7, d0});
                check("capture_addr", 32'({a14, a13}), 32'(r));
                check("capture_m2", 32'(m2), 32'd1);
                check("capture_rw", 32'(rw), 32'd0);
            end
            if (!prev && romsel) begin
                check("romsel_low_width", 32'(low), 32'(hold()));
                low = 0;
            end
            prev = romsel;
            if (done) seen = 1'b1;
            else check("ready_while_busy", 32'(ready), 32'd0);
        end
        check("done_latency", seen ? 32'(n) : 32'hffff_ffff, 32'(lat));
        check("capture_count", 32'(cap.size()), 32'(exp_cap.size()));
        foreach (exp_cap[i]) check("capture_d7_d0", i < cap.size() ? 32'(cap[i]) : 32'h100, 32'(exp_cap[i]));
        check("ready_at_done", 32'(ready), 32'd1);
        if (rs) sh[sel][0][3:2] = 2'b11;
        else begin
`ifdef MMC1_SEQ_AUTO_RESYNC_EN
            sh[sel][0][3:2] = 2'b11;
`endif
            sh[sel][r] = d;
        end
        check_shadows("shadow_after_done");
    endtask

    initial begin
        int falls;
        logic prev;
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        reset_model();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #0;
            check("por_m2", 32'(m2), 32'd0);
            check("por_romsel", 32'(romsel), 32'd1);
            check("por_rw", 32'(rw), 32'd1);
            check("por_a_d", 32'({a14, a13, d0, d7}), 32'd0);
            check("por_ready", 32'(ready), 32'd1);
            check("por_done", 32'(done), 32'd0);
            check_shadows("por_shadow");
        end
        sel = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);

        // abort a write during the hold phase of its third bus cycle
        drive(1'b1, 2'b01, 5'b10101, 1'b0);
        @(posedge CLK);
        #1 drive(1'b0, 2'd0, 5'd0, 1'b0);
        falls = 0;
        prev = 1'b1;
        for (int i = 0; i < 100 && falls < 3; i++) begin
            @(negedge CLK);
            if (prev && !romsel) falls++;
            prev = romsel;
        end
        check("midreset_reached", 32'(falls), 32'd3);
        nRST = 1'b0;
        @(negedge CLK);
        reset_model();
        check("midreset_romsel", 32'(romsel), 32'd1);
        check("midreset_m2", 32'(m2), 32'd0);
        check("midreset_ready", 32'(ready), 32'd1);
        check("midreset_done", 32'(done), 32'd0);
        check_shadows("midreset_shadow");
        nRST = 1'b1;
        @(negedge CLK);

        run_req(2'b00, 5'b00000, 1'b1, 1'b0);
        run_req(2'b11, 5'b10110, 1'b0, 1'b0);
        run_req(2'b00, 5'b00011, 1'b0, 1'b0);
        run_req(2'b00, 5'b00000, 1'b1, 1'b0);
        check("control_after_reset_req", 32'(shv[4:0]), 32'h0f);
        run_req(2'b01, 5'b00101, 1'b0, 1'b1);
        run_req(2'b10, 5'b11000, 1'b0, 1'b0);
        repeat (6) run_req(2'($urandom), 5'($urandom), 1'(($urandom % 4) == 0), 1'($urandom));
        run_req(2'b01, 5'($urandom), 1'b0, 1'b0);

        @(negedge CLK);
        sel = 1'b1;
        #0;
        run_req(2'b11, 5'b01011, 1'b0, 1'b0);
        run_req(2'b00, 5'b00000, 1'b1, 1'b0);
        repeat (5) run_req(2'($urandom), 5'($urandom), 1'(($urandom % 4) == 0), 1'($urandom));
        run_req(2'b10, 5'($urandom), 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
